// File: rtl/accel_seq_alu.sv
// accel_seq_alu: TinyQV-bus ALU peripheral with sequential shift-add MUL and restoring DIV.
// Optional macro ACCEL_STATUS_PMOD_EN mirrors DONE/BUSY/ERR onto uo_out[7:5].
module accel_seq_alu #(
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam int RES_W = 2 * DATA_W;
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [RES_W-1:0]  acc_q, acc_d, result_q, result_d;
    logic [2:0]        opcode_q, opcode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic              wr_ok;
    logic [DATA_W:0]   mul_sum, div_sh, div_tr;
    logic              div_ok;
    logic              unused_ui;

    function automatic logic [RES_W-1:0] alu_single(input logic [2:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD:  return RES_W'(a) + RES_W'(b);
            OP_SUB:  return RES_W'(a) - RES_W'(b);
            OP_AND:  return RES_W'(a & b);
            OP_OR:   return RES_W'(a | b);
            OP_XOR:  return RES_W'(a ^ b);
            default: return '0;
        endcase
    endfunction

    // acc holds {partial product high, multiplier} for MUL and {remainder, quotient} for DIV
    assign mul_sum = {1'b0, acc_q[RES_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opa_q} : {(DATA_W+1){1'b0}});
    assign div_sh  = acc_q[RES_W-1:DATA_W-1];
    assign div_tr  = div_sh - {1'b0, opb_q};
    // a zero divisor always "succeeds", which yields quotient all ones and remainder = A
    assign div_ok  = (opb_q == '0) || !div_tr[DATA_W];
    assign wr_ok   = data_write && !busy_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        opcode_d = opcode_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;

        if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (address == 4'(i))     a_d[8*i +: 8] = data_in;
                if (address == 4'(2 + i)) b_d[8*i +: 8] = data_in;
            end
            if (address == 4'h5 && data_in[1]) begin
                done_d = 1'b0;
                err_d  = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (wr_ok && address == 4'h4) begin
                    opcode_d = data_in[2:0];
                    if (data_in[7]) begin
                        opa_d   = a_q;
                        opb_d   = b_q;
                        acc_d   = (data_in[2:0] == OP_DIV) ? {{DATA_W{1'b0}}, a_q}
                                                           : {{DATA_W{1'b0}}, b_q};
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (opcode_q == OP_MUL || opcode_q == OP_DIV) begin
                    if (opcode_q == OP_MUL)
                        acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                    else if (div_ok)
                        acc_d = {div_tr[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    else
                        acc_d = {div_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        busy_d  = 1'b0;
                        state_d = FINISH;
                    end
                end else begin
                    acc_d   = alu_single(opcode_q, opa_q, opb_q);
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                result_d = acc_q;
                done_d   = 1'b1;
                err_d    = (opcode_q == 3'd7) || (opcode_q == OP_DIV && opb_q == '0);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            opcode_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        data_out = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (address == 4'(i))     data_out = a_q[8*i +: 8];
            if (address == 4'(2 + i)) data_out = b_q[8*i +: 8];
        end
        for (int i = 0; i < 2 * NB; i++) begin
            if (address == 4'(8 + i)) data_out = result_q[8*i +: 8];
        end
        if (address == 4'h4) data_out = {5'b0, opcode_q};
        if (address == 4'h5) data_out = {5'b0, err_q, done_q, busy_q};
    end

`ifdef ACCEL_STATUS_PMOD_EN
    assign uo_out = {done_q, busy_q, err_q, 5'b0};
`else
    assign uo_out = 8'h00;
`endif

    assign unused_ui = &{1'b0, ui_in};

endmodule

// File: tb/tb_accel_seq_alu.sv
// tb_accel_seq_alu: randomized scoreboard bench for accel_seq_alu against a behavioural model.
`timescale 1ns/1ps
module tb_accel_seq_alu;
    localparam int DW = 8;
    localparam int NB = DW / 8;
    localparam int RW = 2 * DW;
    localparam longint DMASK = (longint'(1) << DW) - 1;
    localparam longint RMASK = (longint'(1) << RW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    logic [3:0] wr_addr, rd_addr, mon_addr;
    logic       drv_rd;

    typedef struct {
        longint res;
        bit     err;
        int     lat;
        int     busy;
        longint start;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint a_m, b_m;

    accel_seq_alu #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    assign address = data_write ? wr_addr : (drv_rd ? rd_addr : mon_addr);

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input int op, input longint a, input longint b,
                                  output longint res, output bit err);
        err = 1'b0;
        case (op)
            0: res = (a + b) & RMASK;
            1: res = (a - b) & RMASK;
            2: res = a * b;
            3: begin
                if (b == 0) begin
                    res = (a << DW) | DMASK;
                    err = 1'b1;
                end else begin
                    res = ((a % b) << DW) | (a / b);
                end
            end
            4: res = a & b;
            5: res = a | b;
            6: res = a ^ b;
            default: begin
                res = 0;
                err = 1'b1;
            end
        endcase
    endfunction

    function automatic logic [7:0] exp_uo(input logic [7:0] st);
`ifdef ACCEL_STATUS_PMOD_EN
        return {st[1], st[0], st[2], 5'b0};
`else
        return st & 8'h00;
`endif
    endfunction

    // All driver tasks start and end just after a rising edge.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_addr    = a;
        data_in    = d;
        data_write = 1'b1;
        @(posedge clk);
        #1;
        data_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd_addr = a;
        drv_rd  = 1'b1;
        #1;
        d      = data_out;
        drv_rd = 1'b0;
        chk(name, d, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input longint a, input longint b);
        for (int i = 0; i < NB; i++) begin
            wr(4'(i), 8'(a >> (8 * i)));
            wr(4'(2 + i), 8'(b >> (8 * i)));
        end
        a_m = a;
        b_m = b;
    endtask

    task automatic start(input int op, input bit chk_busy);
        exp_t e;
        wr(4'h4, 8'h80 | 8'(op));
        model(op, a_m, b_m, e.res, e.err);
        e.lat   = (op == 2 || op == 3) ? DW + 1 : 2;
        e.busy  = chk_busy ? ((op == 2 || op == 3) ? DW : 1) : -1;
        e.start = cyc;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            idle(1);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 0);
            sb.delete();
        end
    endtask

    // Monitor: samples STATUS each falling edge the bus is free, scores each DONE rise.
    initial begin
        logic [7:0]  st;
        logic [63:0] res;
        bit          prev_done;
        int          busy_cnt;
        exp_t        e;
        prev_done = 1'b0;
        busy_cnt  = 0;
        mon_addr  = 4'h5;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
                busy_cnt  = 0;
            end else if (!data_write && !drv_rd) begin
                mon_addr = 4'h5;
                #1;
                st = data_out;
                if (st[0]) busy_cnt++;
                if (st[1] && !prev_done) begin
                    res = 0;
                    for (int i = 0; i < 2 * NB; i++) begin
                        mon_addr = 4'(8 + i);
                        #1;
                        res |= 64'(data_out) << (8 * i);
                    end
                    mon_addr = 4'h5;
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'(st), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", res, 64'(e.res));
                        chk("err", 64'(st[2]), 64'(e.err));
                        chk("latency", 64'(cyc - e.start), 64'(e.lat));
                        if (e.busy >= 0) chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
                        chk("uo_out", 64'(uo_out), 64'(exp_uo(st)));
                    end
                    busy_cnt = 0;
                end
                prev_done = st[1];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int     op;
        longint a, b, r;
        bit     er;
        rst        = 1'b1;
        ui_in      = 8'h00;
        data_write = 1'b0;
        data_in    = 8'h00;
        wr_addr    = 4'h0;
        rd_addr    = 4'h0;
        drv_rd     = 1'b0;
        a_m        = 0;
        b_m        = 0;
        idle(3);
        rst = 1'b0;
        idle(1);

        rd_chk("rst_status", 4'h5, 8'h00);
        rd_chk("rst_ctrl", 4'h4, 8'h00);
        rd_chk("rst_a0", 4'h0, 8'h00);
        rd_chk("rst_res0", 4'h8, 8'h00);
        rd_chk("rst_res1", 4'h9, 8'h00);
        chk("rst_uo", 64'(uo_out), 0);
        wr(4'h6, 8'hAB);
        rd_chk("unmapped_read", 4'h6, 8'h00);

        set_ops(64'hF0, 64'h20); start(0, 1); drain(40);
        set_ops(64'hFF, 64'hFF); start(2, 1); drain(40);
        set_ops(200, 7);         start(3, 1); drain(40);
        set_ops(64'h55, 0);      start(3, 1); drain(40);
        set_ops(64'h10, 64'h20); start(1, 1); drain(40);
        start(7, 1); drain(40);
        set_ops(64'hC3, 64'h5A);
        start(4, 1); drain(40);
        start(5, 1); drain(40);
        start(6, 1); drain(40);

        // Writes while busy must be ignored
        set_ops(64'h13, 64'h0B);
        start(2, 0);
        idle(2);
        wr(4'h0, 8'h00);
        wr(4'h4, 8'h80);
        drain(40);
        rd_chk("opcode_hold", 4'h4, 8'h02);
        rd_chk("a_hold", 4'h0, 8'h13);

        // Operand edits after completion leave RESULT alone
        wr(4'h0, 8'h77);
        a_m = (a_m & ~longint'(8'hFF)) | 64'h77;
        model(2, 64'h13, 64'h0B, r, er);
        rd_chk("res_hold0", 4'h8, 8'(r));
        rd_chk("res_hold1", 4'h9, 8'(r >> 8));

        // STATUS clear coinciding with FINISH loses
        start(7, 1);
        idle(1);
        wr(4'h5, 8'h02);
        drain(40);
        rd_chk("finish_wins", 4'h5, 8'h06);
        wr(4'h5, 8'h02);
        rd_chk("status_cleared", 4'h5, 8'h00);

        // Reset in the middle of a division
        set_ops(200, 7);
        start(3, 0);
        idle(3);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_m = 0;
        b_m = 0;
        rd_chk("abort_status", 4'h5, 8'h00);
        rd_chk("abort_ctrl", 4'h4, 8'h00);
        rd_chk("abort_res0", 4'h8, 8'h00);
        rd_chk("abort_res1", 4'h9, 8'h00);
        rd_chk("abort_a0", 4'h0, 8'h00);
        chk("abort_uo", 64'(uo_out), 0);
        set_ops(64'hF0, 64'h20); start(0, 1); drain(40);

        for (int t = 0; t < 40; t++) begin
            op = int'($urandom_range(0, 7));
            a  = longint'($urandom) & DMASK;
            b  = ($urandom_range(0, 4) == 0) ? 0 : (longint'($urandom) & DMASK);
            if ($urandom_range(0, 3) == 0) wr(4'h5, 8'h02);
            set_ops(a, b);
            start(op, 1);
            drain(4 * DW + 10);
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accel_seq_alu.md
Name: accel_seq_alu

Overview:
- Parametrised successor to the 8-bit combinational accelerator peripheral; sits on the TinyQV peripheral bus (4-bit address, 8-bit data).
- Operand width is generic (DATA_W); result register is 2*DATA_W wide and read back bytewise.
- MUL and DIV are multi-cycle sequential units (shift-add, restoring division) under a start/busy/done handshake, replacing the single-cycle combinational datapath.
- Division by zero and reserved opcodes raise a sticky error flag.

Parameters:
- DATA_W, 8: operand width in bits; legal values 8 or 16. Number of operand bytes NB = DATA_W/8.
- RES_W, 2*DATA_W: result width; derived, not overridable.

Ports:
- clk  input  1  system clock (64 MHz nominal)
- rst  input  1  reset is asynchronous and active-high
- ui_in  input  8  PMOD inputs; unused
- uo_out  output  8  PMOD outputs; see Optional Feature
- address  input  4  register address
- data_write  input  1  write strobe, one-cycle
- data_in  input  8  write data, valid with data_write
- data_out  output  8  combinational read data for address

Behaviour:
- Register map:
  - 0x0..0x0+NB-1: A bytes, little-endian.
  - 0x2..0x2+NB-1: B bytes, little-endian.
  - 0x4: CTRL; [2:0] opcode (R/W), bit7 START (write-only, reads 0).
  - 0x5: STATUS; bit0 BUSY, bit1 DONE, bit2 ERR (RO; writing 1 to bit1 clears DONE and ERR).
  - 0x8..0x8+2*NB-1: RESULT bytes, little-endian.
  - All other addresses read 0x00; writes to them are ignored.
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 reserved.
- Width rules:
  - ADD/SUB are computed at RES_W on zero-extended operands; SUB wraps in two's complement (0x10-0x20 = 0xFFF0 for DATA_W=8).
  - Logic ops are zero-extended to RES_W.
  - MUL is unsigned, full RES_W product.
  - DIV is unsigned; RESULT = {remainder, quotient}, each DATA_W bits.
- Reset (async, rst=1):
  - A, B, opcode, RESULT = 0; state = IDLE; BUSY = DONE = ERR = 0; uo_out = 0x00.
- FSM states IDLE, CALC, FINISH:
  - IDLE: a write to 0x4 with data_in[7]=1 latches opcode=data_in[2:0], clears DONE and ERR, loads the working registers from A and B, enters CALC, and sets BUSY on the same edge.
  - CALC, single-cycle ops (0,1,4,5,6,7): one cycle.
  - CALC, MUL/DIV: exactly DATA_W cycles, one iteration per cycle, driven by an iteration counter.
  - FINISH: RESULT written, BUSY=0, DONE=1, then return to IDLE.
- Latency from the start-write edge to DONE=1 with RESULT valid:
  - 2 cycles for single-cycle ops.
  - DATA_W+1 cycles for MUL/DIV.
- Division by zero: quotient = all ones, remainder = A, ERR=1; latency unchanged.
- Opcode 7: RESULT = 0, ERR=1.
- While BUSY:
  - Writes to A, B and CTRL (including START) are ignored.
  - Writes to STATUS are ignored.
  - Reads are live; RESULT holds its previous value until FINISH.
- START written in IDLE while DONE=1 restarts normally; DONE clears on that edge.
- A STATUS clear write in the same cycle as FINISH: FINISH wins (DONE=1).
- Reset asserted mid-CALC aborts immediately to the reset values; no partial RESULT is retained.
- The operand registers are sampled only at START, so later edits of A/B do not disturb a finished RESULT.

Optional Feature:
- Macro ACCEL_STATUS_PMOD_EN.
- Defined: uo_out[7]=DONE, uo_out[6]=BUSY, uo_out[5]=ERR, uo_out[4:0]=0; all registered, same timing as STATUS.
- Undefined: uo_out = 0x00 constantly; no extra logic.

Test Plan:
- DATA_W=8: A=0xF0, B=0x20, CTRL=0x80 (ADD) -> BUSY for 1 cycle, DONE 2 cycles after the write; RESULT bytes 0x8=0x10, 0x9=0x01; ERR=0.
- A=0xFF, B=0xFF, CTRL=0x82 (MUL) -> BUSY for 8 cycles, DONE at cycle 9; RESULT = 0xFE01.
- A=200, B=7, CTRL=0x83 (DIV) -> RESULT = 0x041C after 9 cycles. Repeat with B=0, A=0x55 -> RESULT = 0x55FF, ERR=1.
- Start MUL; at cycle 3 write A=0x00 and CTRL=0x80 -> both ignored; RESULT = product of the original operands, opcode still reads 2.
- Start DIV; assert rst at cycle 4 -> STATUS=0x00, RESULT=0, state IDLE. A fresh ADD afterwards completes normally.
- DATA_W=16: A=0x1234, B=0x0100, MUL -> DONE after 17 cycles; RESULT bytes 0x8..0xB = 00 34 12 00. With ACCEL_STATUS_PMOD_EN defined, uo_out[7:5] tracks STATUS throughout.
